// File: rtl/enc_pkg.sv
// Shared constants and FSM state type for the sequential 8-to-3 encoder.
package enc_pkg;
  localparam int N  = 8;
  localparam int IW = 3;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } enc_state_t;
endpackage

// File: rtl/dec3to8_shift.sv
// 3-to-8 one-hot decoder built from a shift; output is zero when disabled.
module dec3to8_shift (
  input  logic [2:0] in,
  input  logic       en,
  output logic [7:0] out
);
  assign out = en ? (8'b0000_0001 << in) : 8'b0000_0000;
endmodule

// File: rtl/enc8to3_pri.sv
// Combinational lowest-set-bit priority encoder; nz flags any bit set.
module enc8to3_pri
  import enc_pkg::*;
(
  input  logic [N-1:0]  in,
  output logic [IW-1:0] out,
  output logic          nz
);
  always_comb begin
    out = '0;
    nz  = |in;
    // Walk downward so the lowest set bit is the last assignment and wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (in[i]) out = i[IW-1:0];
    end
  end
endmodule

// File: rtl/enc8to3_seq.sv
// Captures an 8-bit request vector and serially emits the index of each set
// bit, lowest first, over valid/ready.
//
// Handshake: an index transfers on a rising edge where valid && ready. valid,
// once raised in SCAN, stays high until the final transfer; out is stable
// while valid && !ready. All outputs come from registers only.
module enc8to3_seq
  import enc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in,
  input  logic          load,
  output logic [IW-1:0] out,
  output logic          valid,
  input  logic          ready,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cnt,
  output logic [1:0]    o_dbg_state
);
  enc_state_t    r_state;
  logic [N-1:0]  r_pend;
  logic [CW-1:0] r_cnt;

  enc_state_t    w_state_nxt;
  logic [N-1:0]  w_pend_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [IW-1:0] w_idx;
  logic          w_nz;
  logic [N-1:0]  w_mask;
  logic [N-1:0]  w_pend_clr;

  enc8to3_pri u_pri (
    .in  (r_pend),
    .out (w_idx),
    .nz  (w_nz)
  );

  dec3to8_shift u_mask (
    .in  (w_idx),
    .en  (1'b1),
    .out (w_mask)
  );

  assign w_pend_clr = r_pend & ~w_mask;

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (load) begin
          w_pend_nxt  = in;
          w_cnt_nxt   = '0;
          w_state_nxt = (in != '0) ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (ready && w_nz) begin
          w_pend_nxt = w_pend_clr;
          w_cnt_nxt  = r_cnt + 4'd1;
          if (w_pend_clr == '0) w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_pend_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign out         = w_idx;
  assign valid       = (r_state == SCAN) && w_nz;
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign cnt         = r_cnt;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_enc8to3_seq.sv
// Self-checking bench for enc8to3_seq: directed timing checks plus an
// expected-index queue checked on every accepted handshake.
module tb_enc8to3_seq;
  logic       clk;
  logic       rst_n;
  logic [7:0] in;
  logic       load;
  logic [2:0] out;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       done;
  logic [3:0] cnt;
  logic [1:0] dbg_state;

  logic [2:0] exp_q[$];
  int         n_cmp;
  int         n_err;
  logic [7:0] or_vec;
  int         hs_cnt;
  int         done_seen;

  enc8to3_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in          (in),
    .load        (load),
    .out         (out),
    .valid       (valid),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .cnt         (cnt),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int popcount(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < 8; i++) if (v[i]) c++;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle load and queues the expected index stream.
  task automatic load_vec(input logic [7:0] v);
    in     = v;
    load   = 1'b1;
    or_vec = 8'h00;
    hs_cnt = 0;
    for (int i = 0; i < 8; i++) if (v[i]) exp_q.push_back(3'(i));
    tick();
    load = 1'b0;
    in   = 8'($urandom_range(0, 255));
  endtask

  // Runs until done is seen, then steps into the following idle cycle.
  task automatic wait_done(input int budget, input bit rnd_ready);
    bit found = 1'b0;
    int cyc   = 0;
    while (!found && cyc < budget) begin
      if (rnd_ready) ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done) found = 1'b1;
      tick();
      cyc++;
    end
    check_eq("done_timeout", 32'(found), 32'd1);
  endtask

  // scoreboard: pop one expected index per accepted handshake
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_idx", 32'(out), 32'hFFFF_FFFF);
      end else begin
        check_eq("idx", 32'(out), 32'(exp_q.pop_front()));
        or_vec = or_vec | (8'b0000_0001 << out);
        hs_cnt++;
      end
    end
    if (rst_n && done) done_seen++;
  end

  initial begin
    logic [2:0] bp_exp[6];
    logic       bp_rdy[6];
    int         saved_done;
    n_cmp = 0; n_err = 0; done_seen = 0; or_vec = 8'h00; hs_cnt = 0;
    bp_exp = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd7};
    bp_rdy = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    // reset with load asserted
    rst_n = 1'b0; load = 1'b1; in = 8'hFF; ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out", 32'(out), 32'd0);
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_cnt", 32'(cnt), 32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    tick();
    rst_n = 1'b1; load = 1'b0;
    tick();
    @(negedge clk);
    check_eq("rst_no_burst", 32'(busy), 32'd0);
    tick();

    // single bit
    ready = 1'b1;
    load_vec(8'b0010_0000);
    @(negedge clk);
    check_eq("single_valid", 32'(valid), 32'd1);
    check_eq("single_out", 32'(out), 32'd5);
    tick();
    @(negedge clk);
    check_eq("single_done", 32'(done), 32'd1);
    check_eq("single_valid_off", 32'(valid), 32'd0);
    check_eq("single_cnt", 32'(cnt), 32'd1);
    tick();
    @(negedge clk);
    check_eq("single_idle_busy", 32'(busy), 32'd0);
    check_eq("single_idle_done", 32'(done), 32'd0);
    tick();

    // full vector, one index per cycle
    load_vec(8'hFF);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("full_valid", 32'(valid), 32'd1);
      check_eq("full_out", 32'(out), 32'(i));
      tick();
    end
    @(negedge clk);
    check_eq("full_done", 32'(done), 32'd1);
    check_eq("full_cnt", 32'(cnt), 32'd8);
    tick();

    // backpressure
    load_vec(8'b1000_0101);
    for (int i = 0; i < 6; i++) begin
      ready = bp_rdy[i];
      @(negedge clk);
      check_eq("bp_valid", 32'(valid), 32'd1);
      check_eq("bp_out", 32'(out), 32'(bp_exp[i]));
      tick();
    end
    @(negedge clk);
    check_eq("bp_done", 32'(done), 32'd1);
    check_eq("bp_cnt", 32'(cnt), 32'd3);
    tick();

    // zero vector
    ready = 1'b1;
    load_vec(8'h00);
    @(negedge clk);
    check_eq("zero_done", 32'(done), 32'd1);
    check_eq("zero_valid", 32'(valid), 32'd0);
    check_eq("zero_cnt", 32'(cnt), 32'd0);
    tick();
    @(negedge clk);
    check_eq("zero_idle", 32'(busy), 32'd0);
    check_eq("zero_hs", 32'(hs_cnt), 32'd0);
    tick();

    // load during SCAN is ignored
    ready = 1'b0;
    load_vec(8'h0C);
    load = 1'b1; in = 8'h01;
    @(negedge clk);
    check_eq("ign_out", 32'(out), 32'd2);
    tick();
    load = 1'b0;
    @(negedge clk);
    check_eq("ign_hold", 32'(out), 32'd2);
    check_eq("ign_cnt_hold", 32'(cnt), 32'd0);
    ready = 1'b1;
    tick();
    wait_done(20, 1'b0);
    check_eq("ign_cnt", 32'(cnt), 32'd2);
    check_eq("ign_vec", 32'(or_vec), 32'h0C);

    // mid-burst reset
    load_vec(8'hF0);
    repeat (2) begin
      @(negedge clk);
      tick();
    end
    rst_n = 1'b0; ready = 1'b0;
    saved_done = done_seen;
    exp_q.delete();
    tick();
    @(negedge clk);
    check_eq("mrst_valid", 32'(valid), 32'd0);
    check_eq("mrst_cnt", 32'(cnt), 32'd0);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check_eq("mrst_no_done", 32'(done_seen), 32'(saved_done));
    ready = 1'b1;
    load_vec(8'h03);
    wait_done(20, 1'b0);
    check_eq("mrst_next_cnt", 32'(cnt), 32'd2);
    check_eq("mrst_next_vec", 32'(or_vec), 32'h03);

    // round trip over every vector with random ready
    for (int v = 0; v < 256; v++) begin
      ready = 1'($urandom_range(0, 1));
      load_vec(8'(v));
      wait_done(80, 1'b1);
      check_eq("rt_vec", 32'(or_vec), 32'(v));
      check_eq("rt_cnt", 32'(cnt), 32'(popcount(8'(v))));
      check_eq("rt_hs", 32'(hs_cnt), 32'(popcount(8'(v))));
    end

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
